radar_pulse_sequencer: RTL and testbench

//  Generates pulse timing for the radar sample path: run_tx, run_rx and adc_last.

---
 rtl/radar_pulse_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_radar_pulse_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/radar_pulse_sequencer.sv
// Radar pulse sequencer: PRI-periodic run_tx / run_rx / adc_last generation.
// Optional external PRI trigger enabled by defining RADAR_SEQ_EXT_TRIG_EN.
module radar_pulse_sequencer #(
  parameter int CNT_WIDTH       = 32,
  parameter int PULSE_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_start,
  input  logic                       cfg_stop,
  input  logic [CNT_WIDTH-1:0]       cfg_pri,
  input  logic [CNT_WIDTH-1:0]       cfg_tx_len,
  input  logic [CNT_WIDTH-1:0]       cfg_rx_delay,
  input  logic [CNT_WIDTH-1:0]       cfg_rx_len,
  input  logic [PULSE_CNT_WIDTH-1:0] cfg_num_pulses,
`ifdef RADAR_SEQ_EXT_TRIG_EN
  input  logic                       ext_trig,
`endif
  output logic                       run_tx,
  output logic                       run_rx,
  output logic                       adc_last,
  output logic [PULSE_CNT_WIDTH-1:0] pulse_index,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int CW = CNT_WIDTH;
  localparam int PW = PULSE_CNT_WIDTH;
  localparam logic [CW:0]   W1 = 1;
  localparam logic [CW:0]   W2 = 2;
  localparam logic [CW-1:0] C1 = 1;
  localparam logic [PW-1:0] P1 = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_STOPPING,
    S_WAIT
  } state_t;

`ifdef RADAR_SEQ_EXT_TRIG_EN
  localparam state_t S_PRI = S_WAIT;
`else
  localparam state_t S_PRI = S_ACTIVE;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   pri_q, tx_q, dly_q, rxl_q;
  logic [PW-1:0]   num_q;
  logic            run_tx_q, run_rx_q, adc_q;
  logic            busy_q, done_q, err_q;

  logic            latch, done_d, err_d;
  logic            cfg_ok, at_wrap, at_final, at_rx_end;
  logic            act_d, rx_st_d;
  logic            run_tx_d, run_rx_d, adc_d;
  logic [CW:0]     cfg_end, end_q, end_e, cnt_w;
  logic [CW-1:0]   tx_e, dly_e;
  logic            trig_edge;

`ifdef RADAR_SEQ_EXT_TRIG_EN
  logic trig_q;
  assign trig_edge = ext_trig & ~trig_q;
`else
  assign trig_edge = 1'b0;
`endif

  // One extra bit keeps delay+len from wrapping past the PRI check
  assign cfg_end = {1'b0, cfg_rx_delay} + {1'b0, cfg_rx_len};
  assign cfg_ok  = ({1'b0, cfg_pri} >= W2)
                && (cfg_rx_len != '0)
                && (cfg_tx_len <= cfg_pri)
                && (cfg_end <= {1'b0, cfg_pri});

  assign end_q     = {1'b0, dly_q} + {1'b0, rxl_q};
  assign at_wrap   = (cnt_q == pri_q - C1);
  assign at_final  = (num_q != '0) && (idx_q + P1 == num_q);
  assign at_rx_end = ({1'b0, cnt_q} == end_q - W1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    latch   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_ok) begin
            latch   = 1'b1;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_PRI;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (at_wrap && at_final) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (cfg_stop) begin
          // Finish the rx window if any of it is still ahead
          if ({1'b0, cnt_q} + W1 < end_q) begin
            state_d = S_STOPPING;
            cnt_d   = cnt_q + C1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end else if (at_wrap) begin
          cnt_d   = '0;
          idx_d   = idx_q + P1;
          state_d = S_PRI;
        end else begin
          cnt_d = cnt_q + C1;
        end
      end
      S_STOPPING: begin
        if (at_rx_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + C1;
        end
      end
      S_WAIT: begin
        if (cfg_stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (trig_edge) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_e  = latch ? cfg_tx_len   : tx_q;
  assign dly_e = latch ? cfg_rx_delay : dly_q;
  assign end_e = latch ? cfg_end      : end_q;
  assign cnt_w = {1'b0, cnt_d};

  assign act_d    = (state_d == S_ACTIVE);
  assign rx_st_d  = act_d || (state_d == S_STOPPING);
  assign run_tx_d = act_d && (cnt_d < tx_e);
  assign run_rx_d = rx_st_d && (cnt_d >= dly_e) && (cnt_w < end_e);
  assign adc_d    = rx_st_d && (cnt_w == end_e - W1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      pri_q    <= '0;
      tx_q     <= '0;
      dly_q    <= '0;
      rxl_q    <= '0;
      num_q    <= '0;
      run_tx_q <= 1'b0;
      run_rx_q <= 1'b0;
      adc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef RADAR_SEQ_EXT_TRIG_EN
      trig_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      if (latch) begin
        pri_q <= cfg_pri;
        tx_q  <= cfg_tx_len;
        dly_q <= cfg_rx_delay;
        rxl_q <= cfg_rx_len;
        num_q <= cfg_num_pulses;
      end
      run_tx_q <= run_tx_d;
      run_rx_q <= run_rx_d;
      adc_q    <= adc_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef RADAR_SEQ_EXT_TRIG_EN
      trig_q   <= ext_trig;
`endif
    end
  end

  assign run_tx      = run_tx_q;
  assign run_rx      = run_rx_q;
  assign adc_last    = adc_q;
  assign pulse_index = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_radar_pulse_sequencer.sv
// Bench for radar_pulse_sequencer: directed scenarios then random traffic
// against a timeline model (pulse = k / pri, phase = k % pri).
module tb_radar_pulse_sequencer;

  logic        clk = 1'b0;
  logic        reset, cfg_start, cfg_stop;
  logic [31:0] cfg_pri, cfg_tx_len, cfg_rx_delay, cfg_rx_len;
  logic [15:0] cfg_num_pulses;
  logic        run_tx, run_rx, adc_last, busy, done, cfg_err;
  logic [15:0] pulse_index;

  always #5 clk = ~clk;

  radar_pulse_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_pri        (cfg_pri),
    .cfg_tx_len     (cfg_tx_len),
    .cfg_rx_delay   (cfg_rx_delay),
    .cfg_rx_len     (cfg_rx_len),
    .cfg_num_pulses (cfg_num_pulses),
`ifdef RADAR_SEQ_EXT_TRIG_EN
    .ext_trig       (1'b0),
`endif
    .run_tx         (run_tx),
    .run_rx         (run_rx),
    .adc_last       (adc_last),
    .pulse_index    (pulse_index),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: a run is a timeline k = 0,1,2,... from the start
  bit     run_on, stopped;
  longint k, stop_at, tx_cut, lim;
  longint m_pri, m_tx, m_dly, m_len, m_n;
  bit     e_tx, e_rx, e_adc, e_busy, e_done, e_err;
  int     e_idx;

  function automatic bit cfg_valid(longint p, longint t,
                                   longint d, longint l);
    return (p >= 2) && (l >= 1) && (t <= p) && (d + l <= p);
  endfunction

  task automatic show(longint kk);
    longint ph;
    ph     = kk % m_pri;
    e_tx   = (ph < m_tx) && (kk < tx_cut);
    e_rx   = (ph >= m_dly) && (ph < m_dly + m_len);
    e_adc  = (ph == m_dly + m_len - 1);
    e_idx  = int'((kk / m_pri) % 65536);
    e_busy = 1'b1;
  endtask

  task automatic clear_outs();
    e_tx = 0; e_rx = 0; e_adc = 0; e_busy = 0;
  endtask

  task automatic model_step();
    longint ph;
    e_done = 0;
    e_err  = 0;
    if (reset) begin
      run_on = 0;
      clear_outs();
      e_idx = 0;
    end else if (!run_on) begin
      clear_outs();
      if (cfg_start) begin
        if (cfg_valid(longint'(cfg_pri), longint'(cfg_tx_len),
                      longint'(cfg_rx_delay), longint'(cfg_rx_len))) begin
          m_pri   = longint'(cfg_pri);
          m_tx    = longint'(cfg_tx_len);
          m_dly   = longint'(cfg_rx_delay);
          m_len   = longint'(cfg_rx_len);
          m_n     = longint'(cfg_num_pulses);
          run_on  = 1;
          stopped = 0;
          k       = 0;
          stop_at = 64'h7fff_ffff_ffff;
          tx_cut  = 64'h7fff_ffff_ffff;
          show(k);
        end else begin
          e_err = 1;
        end
      end
    end else begin
      if (cfg_stop && !stopped) begin
        stopped = 1;
        ph      = k % m_pri;
        tx_cut  = k + 1;
        if (ph + 1 < m_dly + m_len) stop_at = k - ph + m_dly + m_len;
        else                        stop_at = k + 1;
      end
      k   = k + 1;
      lim = stop_at;
      if (m_n != 0 && m_n * m_pri < lim) lim = m_n * m_pri;
      if (k >= lim) begin
        run_on = 0;
        e_done = 1;
        clear_outs();
      end else begin
        show(k);
      end
    end
  endtask

  task automatic set_cfg(int p, int t, int d, int l, int n);
    cfg_pri        = p;
    cfg_tx_len     = t;
    cfg_rx_delay   = d;
    cfg_rx_len     = l;
    cfg_num_pulses = 16'(n);
  endtask

  task automatic gen_cfg(bit bad);
    int p, l, d, t;
    p = $urandom_range(2, 12);
    l = $urandom_range(1, p);
    d = $urandom_range(0, p - l);
    case ($urandom_range(0, 3))
      0:       t = 0;
      1:       t = p;
      default: t = $urandom_range(0, p);
    endcase
    if ($urandom_range(0, 3) == 0) d = p - l;
    set_cfg(p, t, d, l, $urandom_range(0, 3));
    if (bad) begin
      case ($urandom_range(0, 4))
        0: cfg_pri = $urandom_range(0, 1);
        1: cfg_rx_len = 0;
        2: cfg_tx_len = p + 1;
        3: cfg_rx_delay = p - l + 1;
        default: begin
          cfg_rx_delay = 32'hffff_ffff;
          cfg_rx_len   = 1;
        end
      endcase
    end
  endtask

  initial begin
    reset     = 1'b1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    run_on = 0;
    clear_outs();
    e_idx = 0; e_done = 0; e_err = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      reset     = (cyc < 3);
      cfg_start = 1'b0;
      cfg_stop  = 1'b0;
      case (cyc)
        5:   begin cfg_start = 1; set_cfg(10, 3, 4, 5, 2); end
        30:  begin cfg_start = 1; set_cfg(8, 2, 3, 3, 0); end
        40:  begin cfg_start = 1; set_cfg(5, 1, 1, 1, 1); end
        75:  cfg_stop = 1;
        90:  begin cfg_start = 1; set_cfg(10, 3, 4, 5, 0); end
        106: reset = 1;
        110: begin cfg_start = 1; set_cfg(5, 2, 0, 5, 1); end
        120: begin cfg_start = 1; set_cfg(10, 3, 6, 5, 1); end
        125: cfg_stop = 1;
        default: begin
          if (cyc >= 130) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!run_on) begin
              if ($urandom_range(0, 2) == 0) begin
                cfg_start = 1;
                gen_cfg($urandom_range(0, 4) == 0);
              end
              cfg_stop = ($urandom_range(0, 9) == 0);
            end else begin
              cfg_stop  = ($urandom_range(0, (m_n == 0) ? 12 : 40) == 0);
              cfg_start = ($urandom_range(0, 9) == 0);
              if ($urandom_range(0, 3) == 0) gen_cfg($urandom_range(0, 1) == 1);
            end
          end
        end
      endcase
      @(posedge clk);
      model_step();
      #1;
      chk("run_tx",      32'(run_tx),      32'(e_tx));
      chk("run_rx",      32'(run_rx),      32'(e_rx));
      chk("adc_last",    32'(adc_last),    32'(e_adc));
      chk("busy",        32'(busy),        32'(e_busy));
      chk("done",        32'(done),        32'(e_done));
      chk("cfg_err",     32'(cfg_err),     32'(e_err));
      chk("pulse_index", 32'(pulse_index), 32'(e_idx));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
